// File: rtl/adc_accum.sv
// adc_accum: multi-channel accumulate-and-average ADC front end.
// Each conversion sums 2^LOG2_SAMPLES consecutive samples per channel in
// full-width accumulators and registers the per-channel mean.
// Supports one-shot and continuous (cont) conversion.
//
// Optional build macro: ADC_ROUND_EN
//   defined   -> result = (sum + 2^(LOG2_SAMPLES-1)) >> LOG2_SAMPLES (round half up)
//   undefined -> result = sum >> LOG2_SAMPLES (truncate)
//
// Ports:
//   clk            in   single clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   begin/restart a conversion (wins over everything)
//   cont           in   continuous mode, sampled on the last-sample cycle
//   analog_input   in   CHANNELS*DATA_W, channel c at [c*DATA_W +: DATA_W]
//   digital_output out  CHANNELS*DATA_W registered averages, same packing
//   busy           out  high while in ACCUM
//   done           out  one-cycle pulse when digital_output updates
//   valid          out  digital_output holds a completed result

// Per-channel accumulator and result register.
module adc_accum_lane #(
  parameter int DATA_W       = 8,
  parameter int LOG2_SAMPLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,     // restart: drop partial sum
  input  logic              acc_en,  // capture this cycle's sample
  input  logic              fire,    // last sample: publish result, rearm
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] result
);
  localparam int ACC_W = DATA_W + LOG2_SAMPLES;
  localparam int SUM_W = ACC_W + 1;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [SUM_W-1:0]  sum, rnd;
  logic              lane_unused;

  // One spare bit so the rounding add cannot wrap.
  assign sum = SUM_W'(acc_q) + SUM_W'(sample);

`ifdef ADC_ROUND_EN
  assign rnd = sum + (SUM_W'(1) << (LOG2_SAMPLES - 1));
`else
  assign rnd = sum;
`endif

  // Top bit is provably zero; low bits are the discarded fraction.
  assign lane_unused = ^{rnd[SUM_W-1], rnd[LOG2_SAMPLES-1:0], sum[SUM_W-1]};

  always_comb begin
    acc_d    = acc_q;
    result_d = result_q;
    if (clr || fire)  acc_d = '0;
    else if (acc_en)  acc_d = sum[ACC_W-1:0];
    if (fire)         result_d = rnd[LOG2_SAMPLES +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
endmodule

module adc_accum #(
  parameter int DATA_W       = 8,
  parameter int CHANNELS     = 4,
  parameter int LOG2_SAMPLES = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         cont,
  input  logic [CHANNELS*DATA_W-1:0]   analog_input,
  output logic [CHANNELS*DATA_W-1:0]   digital_output,
  output logic                         busy,
  output logic                         done,
  output logic                         valid
);
  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [LOG2_SAMPLES-1:0]   cnt_q, cnt_d;
  logic                      done_q, done_d;
  logic                      valid_q, valid_d;
  logic                      clr, acc_en, fire, last;

  logic [CHANNELS-1:0][DATA_W-1:0] samp;
  logic [CHANNELS-1:0][DATA_W-1:0] res;

  assign samp = analog_input;
  assign last = &cnt_q;  // counter == N-1

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (!start && last && !cont) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath controls. start outranks accumulation and the last sample.
  always_comb begin
    clr    = start;
    acc_en = (state_q == ACCUM) && !start;
    fire   = acc_en && last;
  end

  always_comb begin
    cnt_d   = cnt_q;
    done_d  = fire;
    valid_d = valid_q;
    if (clr || fire) cnt_d = '0;
    else if (acc_en) cnt_d = cnt_q + LOG2_SAMPLES'(1);
    if (start)       valid_d = 1'b0;
    else if (fire)   valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    adc_accum_lane #(
      .DATA_W       (DATA_W),
      .LOG2_SAMPLES (LOG2_SAMPLES)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .acc_en (acc_en),
      .fire   (fire),
      .sample (samp[c]),
      .result (res[c])
    );
  end

  assign digital_output = res;
  assign busy           = (state_q == ACCUM);
  assign done           = done_q;
  assign valid          = valid_q;
endmodule

// File: tb/tb_adc_accum.sv
module tb_adc_accum;
  localparam int DW = 8;
  localparam int CH = 4;
  localparam int L2 = 3;
  localparam int N  = 1 << L2;

  logic clk = 1'b0;
  logic rst_n;
  logic start, cont;
  logic [CH*DW-1:0] ain, dout;
  logic busy, done, valid;

  always #5 clk = ~clk;

  adc_accum #(.DATA_W(DW), .CHANNELS(CH), .LOG2_SAMPLES(L2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cont           (cont),
    .analog_input   (ain),
    .digital_output (dout),
    .busy           (busy),
    .done           (done),
    .valid          (valid)
  );

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 0;

  // Reference model: samples of the conversion in progress, results awaiting done.
  logic [CH*DW-1:0] conv_q[$];
  logic [CH*DW-1:0] exp_q[$];
  logic [CH*DW-1:0] m_out = '0;
  bit m_active = 0, m_valid = 0, m_done = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [CH*DW-1:0] rep(input logic [DW-1:0] v);
    return {CH{v}};
  endfunction

  // Mean of the collected samples per channel, straight from the definition.
  task automatic model_step(input logic s, input logic c, input logic [CH*DW-1:0] d);
    logic [CH*DW-1:0] r;
    int sum;
    r = '0;
    m_done = 0;
    if (s) begin
      conv_q.delete();
      m_active = 1;
      m_valid  = 0;
    end else if (m_active) begin
      conv_q.push_back(d);
      if (conv_q.size() == N) begin
        for (int ch = 0; ch < CH; ch++) begin
          sum = 0;
          foreach (conv_q[i]) sum += int'(conv_q[i][ch*DW +: DW]);
`ifdef ADC_ROUND_EN
          sum += N / 2;
`endif
          r[ch*DW +: DW] = DW'(sum / N);
        end
        exp_q.push_back(r);
        m_out   = r;
        m_valid = 1;
        m_done  = 1;
        conv_q.delete();
        if (!c) m_active = 0;
      end
    end
  endtask

  task automatic model_reset();
    conv_q.delete();
    exp_q.delete();
    m_out = '0; m_active = 0; m_valid = 0; m_done = 0;
  endtask

  task automatic cyc(input logic s, input logic c, input logic [CH*DW-1:0] d);
    @(negedge clk);
    start = s; cont = c; ain = d;
    @(posedge clk);
    model_step(s, c, d);
  endtask

  function automatic logic [CH*DW-1:0] rnd_data();
    logic [CH*DW-1:0] d;
    for (int ch = 0; ch < CH; ch++) begin
      case ($urandom_range(0, 3))
        0:       d[ch*DW +: DW] = '0;
        1:       d[ch*DW +: DW] = '1;
        default: d[ch*DW +: DW] = DW'($urandom_range(0, 255));
      endcase
    end
    return d;
  endfunction

  // Monitor: status every cycle, results popped from the scoreboard on done.
  always @(negedge clk) begin
    logic [CH*DW-1:0] e;
    if (mon_en) begin
      chk("busy",  busy,  m_active);
      chk("valid", valid, m_valid);
      chk("done",  done,  m_done);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected: done=1 with no pending result at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("result", dout, e);
        end
      end
      chk("dout_hold", dout, m_out);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic c;
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; ain = '0;
    #3;
    chk("rst_dout",  dout,  0);
    chk("rst_busy",  busy,  0);
    chk("rst_done",  done,  0);
    chk("rst_valid", valid, 0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    mon_en = 1;

    // All channels 100
    cyc(1, 0, rep(8'd100));
    repeat (N) cyc(0, 0, rep(8'd100));
    repeat (3) cyc(0, 0, rep(8'd7));

    // Per-channel extremes, then all 255
    cyc(1, 0, '0);
    repeat (N) cyc(0, 0, {8'd255, 8'd254, 8'd1, 8'd0});
    cyc(1, 0, '0);
    repeat (N) cyc(0, 0, rep(8'd255));
    repeat (2) cyc(0, 0, '0);

    // Alternating 0/1 over a conversion (exercises the rounding boundary)
    cyc(1, 0, '0);
    for (int i = 0; i < N; i++) cyc(0, 0, rep(DW'(i % 2)));
    repeat (2) cyc(0, 0, '0);

    // Restart at sample 5
    cyc(1, 0, '0);
    repeat (5) cyc(0, 0, rep(8'd200));
    cyc(1, 0, rep(8'd200));
    repeat (N) cyc(0, 0, rep(8'd10));
    repeat (2) cyc(0, 0, '0);

    // Continuous mode, drop cont mid-conversion
    cyc(1, 1, '0);
    repeat (3*N + 3) cyc(0, 1, rep(8'd42));
    repeat (N + 2) cyc(0, 0, rep(8'd42));

    // start held, then start on the last-sample cycle
    repeat (5) cyc(1, 0, rep(8'd9));
    repeat (N - 1) cyc(0, 0, rep(8'd9));
    cyc(1, 0, rep(8'd9));
    repeat (N) cyc(0, 0, rep(8'd33));
    repeat (2) cyc(0, 0, '0);

    // Asynchronous reset at sample 4
    cyc(1, 0, rep(8'd77));
    repeat (4) cyc(0, 0, rep(8'd77));
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout",  dout,  0);
    chk("arst_busy",  busy,  0);
    chk("arst_done",  done,  0);
    chk("arst_valid", valid, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    mon_en = 1;
    repeat (12) cyc(0, 0, rnd_data());
    cyc(1, 0, '0);
    repeat (N) cyc(0, 0, rep(8'd55));
    repeat (2) cyc(0, 0, '0);

    // Randomized traffic
    c = 0;
    repeat (800) begin
      if ($urandom_range(0, 29) == 0) c = ~c;
      cyc(($urandom_range(0, 19) == 0), c, rnd_data());
    end
    repeat (2*N + 2) cyc(0, 0, rnd_data());

    @(negedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
